// File: rtl/rom_port_arbiter.sv
// Shares the program ROM read port between instruction fetch and LPM, one read per clock.
// Grant is issued on the request edge and valid follows one cycle later. Requests that lose arbitration are simply held by the requester.
module rom_port_arbiter #(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   input  logic                  if_flush,
   output logic                  if_grant,
   output logic                  if_valid,
   output logic [DATA_WIDTH-1:0] if_data,
   output logic [ADDR_WIDTH-1:0] if_rsp_addr,
   input  logic                  lpm_req,
   input  logic [ADDR_WIDTH:0]   lpm_addr,
   output logic                  lpm_grant,
   output logic                  lpm_valid,
   output logic [7:0]            lpm_data,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data
);

   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LPM} owner_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   owner_t                owner_q, owner_d;
   logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
   logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
   logic                  lpm_hi_q, lpm_hi_d;
   logic [3:0]            starve_q, starve_d;
   logic                  if_grant_q, if_grant_d;
   logic                  lpm_grant_q, lpm_grant_d;
   logic                  if_valid_q, if_valid_d;
   logic                  lpm_valid_q, lpm_valid_d;
   logic [DATA_WIDTH-1:0] if_data_q, if_data_d;
   logic [ADDR_WIDTH-1:0] if_rsp_addr_q, if_rsp_addr_d;
   logic [7:0]            lpm_data_q, lpm_data_d;
   logic                  win_if, win_lpm;

   always_comb begin
      owner_d       = OWN_NONE;
      rom_addr_d    = rom_addr_q;
      rsp_addr_d    = rsp_addr_q;
      lpm_hi_d      = lpm_hi_q;
      starve_d      = starve_q;
      if_grant_d    = 1'b0;
      lpm_grant_d   = 1'b0;
      if_valid_d    = 1'b0;
      lpm_valid_d   = 1'b0;
      if_data_d     = if_data_q;
      if_rsp_addr_d = if_rsp_addr_q;
      lpm_data_d    = lpm_data_q;

      // Fetch wins ties until LPM has waited STARVE_LIMIT fetch grants.
      win_if  = if_req && (!lpm_req || starve_q != LIMIT);
      win_lpm = lpm_req && !win_if;

      if (win_if) begin
         owner_d    = OWN_IF;
         rom_addr_d = if_addr;
         rsp_addr_d = if_addr;
         if_grant_d = 1'b1;
         if (!lpm_req)
            starve_d = 4'd0;
         else if (starve_q != LIMIT)
            starve_d = starve_q + 4'd1;
      end else if (win_lpm) begin
         owner_d     = OWN_LPM;
         rom_addr_d  = lpm_addr[ADDR_WIDTH:1];
         lpm_hi_d    = lpm_addr[0];
         lpm_grant_d = 1'b1;
         starve_d    = 4'd0;
      end else begin
         starve_d = 4'd0;
      end

      // Retire the read granted on the previous edge; ROM data was latched mid-cycle.
      case (owner_q)
         OWN_IF: begin
            if_data_d     = rom_data;
            if_rsp_addr_d = rsp_addr_q;
            if_valid_d    = !if_flush;
         end
         OWN_LPM: begin
            lpm_data_d  = lpm_hi_q ? rom_data[15:8] : rom_data[7:0];
            lpm_valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q       <= OWN_NONE;
         rom_addr_q    <= '0;
         rsp_addr_q    <= '0;
         lpm_hi_q      <= 1'b0;
         starve_q      <= 4'd0;
         if_grant_q    <= 1'b0;
         lpm_grant_q   <= 1'b0;
         if_valid_q    <= 1'b0;
         lpm_valid_q   <= 1'b0;
         if_data_q     <= '0;
         if_rsp_addr_q <= '0;
         lpm_data_q    <= '0;
      end else begin
         owner_q       <= owner_d;
         rom_addr_q    <= rom_addr_d;
         rsp_addr_q    <= rsp_addr_d;
         lpm_hi_q      <= lpm_hi_d;
         starve_q      <= starve_d;
         if_grant_q    <= if_grant_d;
         lpm_grant_q   <= lpm_grant_d;
         if_valid_q    <= if_valid_d;
         lpm_valid_q   <= lpm_valid_d;
         if_data_q     <= if_data_d;
         if_rsp_addr_q <= if_rsp_addr_d;
         lpm_data_q    <= lpm_data_d;
      end
   end

   assign if_grant    = if_grant_q;
   assign lpm_grant   = lpm_grant_q;
   assign if_valid    = if_valid_q;
   assign lpm_valid   = lpm_valid_q;
   assign if_data     = if_data_q;
   assign if_rsp_addr = if_rsp_addr_q;
   assign lpm_data    = lpm_data_q;
   assign rom_addr    = rom_addr_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomized and directed bench: a per-edge reference model queues expected outputs, a negedge monitor compares.
module tb_rom_port_arbiter;

   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_req = 1'b0;
   logic [7:0]  if_addr = '0;
   logic        if_flush = 1'b0;
   logic        if_grant, if_valid;
   logic [15:0] if_data;
   logic [7:0]  if_rsp_addr;
   logic        lpm_req = 1'b0;
   logic [8:0]  lpm_addr = '0;
   logic        lpm_grant, lpm_valid;
   logic [7:0]  lpm_data;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data = '0;

   rom_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_grant(if_grant), .if_valid(if_valid), .if_data(if_data), .if_rsp_addr(if_rsp_addr),
      .lpm_req(lpm_req), .lpm_addr(lpm_addr), .lpm_grant(lpm_grant), .lpm_valid(lpm_valid),
      .lpm_data(lpm_data), .rom_addr(rom_addr), .rom_data(rom_data)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [16];
   initial begin
      mem[0]  = 16'hE005; mem[1]  = 16'hE01F; mem[2]  = 16'h930F; mem[3]  = 16'h1234;
      mem[4]  = 16'hA55A; mem[5]  = 16'hBEEF; mem[6]  = 16'h0F0F; mem[7]  = 16'hC3D2;
      mem[8]  = 16'h7E81; mem[9]  = 16'h4242; mem[10] = 16'hFFFF; mem[11] = 16'h0001;
      mem[12] = 16'h930F; mem[13] = 16'h8000; mem[14] = 16'h5AC3; mem[15] = 16'h2468;
   end

   function automatic logic [15:0] rom_word(input logic [7:0] a);
      return (a < 8'd16) ? mem[a[3:0]] : 16'h0000;
   endfunction

   // ROM registers its output on the falling edge.
   always @(negedge clk) rom_data <= rom_word(rom_addr);

   typedef struct {
      logic        ig, lg, iv, lv;
      logic [15:0] id;
      logic [7:0]  ira, ld, ra;
   } rec_t;

   rec_t exp_q[$];
   int   n_pass = 0, n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
   endtask

   // Reference model state: who won the last edge and what it asked for.
   int          m_prev = 0;       // 0 none, 1 fetch, 2 lpm
   logic [7:0]  m_prev_word = '0;
   logic        m_prev_hi = 1'b0;
   int          m_starve = 0;
   logic [15:0] m_if_data = '0;
   logic [7:0]  m_if_rsp = '0, m_lpm_data = '0, m_rom_addr = '0;

   task automatic model_edge();
      rec_t r;
      int   win;
      logic [15:0] w;
      r.ig = 0; r.lg = 0; r.iv = 0; r.lv = 0;
      if (reset) begin
         m_prev = 0; m_starve = 0; m_if_data = '0; m_if_rsp = '0;
         m_lpm_data = '0; m_rom_addr = '0;
      end else begin
         w = rom_word(m_prev_word);
         if (m_prev == 1) begin
            m_if_data = w; m_if_rsp = m_prev_word; r.iv = !if_flush;
         end else if (m_prev == 2) begin
            m_lpm_data = m_prev_hi ? w[15:8] : w[7:0]; r.lv = 1;
         end
         if (if_req && lpm_req) win = (m_starve == LIM) ? 2 : 1;
         else if (if_req) win = 1;
         else if (lpm_req) win = 2;
         else win = 0;
         if (win == 1) begin
            r.ig = 1; m_rom_addr = if_addr; m_prev_word = if_addr;
            m_starve = lpm_req ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
         end else if (win == 2) begin
            r.lg = 1; m_rom_addr = lpm_addr[8:1]; m_prev_word = lpm_addr[8:1];
            m_prev_hi = lpm_addr[0]; m_starve = 0;
         end else begin
            m_starve = 0;
         end
         m_prev = win;
      end
      r.id = m_if_data; r.ira = m_if_rsp; r.ld = m_lpm_data; r.ra = m_rom_addr;
      exp_q.push_back(r);
   endtask

   task automatic step(input logic rst, input logic ir, input logic [7:0] ia,
                       input logic lr, input logic [8:0] la, input logic fl);
      reset = rst; if_req = ir; if_addr = ia; lpm_req = lr; lpm_addr = la; if_flush = fl;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   always @(negedge clk) begin
      rec_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("if_grant",    32'(if_grant),    32'(e.ig));
         chk("lpm_grant",   32'(lpm_grant),   32'(e.lg));
         chk("if_valid",    32'(if_valid),    32'(e.iv));
         chk("lpm_valid",   32'(lpm_valid),   32'(e.lv));
         chk("if_data",     32'(if_data),     32'(e.id));
         chk("if_rsp_addr", 32'(if_rsp_addr), 32'(e.ira));
         chk("lpm_data",    32'(lpm_data),    32'(e.ld));
         chk("rom_addr",    32'(rom_addr),    32'(e.ra));
      end
   end

   initial begin
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      // back-to-back fetches from reset
      step(0, 1, 8'd0, 0, 0, 0);
      step(0, 1, 8'd1, 0, 0, 0);
      step(0, 1, 8'd2, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      // LPM byte reads
      step(0, 0, 0, 1, 9'd1, 0);
      step(0, 0, 0, 1, 9'd2, 0);
      step(0, 0, 0, 1, 9'd4, 0);
      step(0, 0, 0, 0, 0, 0);
      // contention: both held continuously
      for (int i = 0; i < 15; i++) step(0, 1, 8'd3, 1, 9'd7, 0);
      step(0, 0, 0, 0, 0, 0);
      // flush kills fetch 5, branch target 12 granted on the same edge
      step(0, 1, 8'd5, 0, 0, 0);
      step(0, 1, 8'd12, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      // beyond ROM contents
      step(0, 1, 8'd16, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      // reset right after an LPM grant
      step(0, 0, 0, 1, 9'd3, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 8'd1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      // randomized traffic
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 49) == 0), 1'($urandom), 8'($urandom_range(0, 20)),
              1'($urandom), 9'($urandom_range(0, 41)), ($urandom_range(0, 3) == 0));
      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
